// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: one bit per cycle, signed and unsigned.
// Optional macro MULDIV_ZERO_SKIP_EN: zero operands finish in one cycle.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             abort,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic             ready,
   output logic             busy,
   output logic             div_zero
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_FIX,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         op_q, op_d;
   logic               sa_q, sa_d;
   logic               sb_q, sb_d;
   logic [WIDTH-1:0]   bmag_q, bmag_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;
   logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic [WIDTH-1:0]   lo_q, lo_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               dz_q, dz_d;

   logic [WIDTH-1:0]   amag, bmag;
   logic [WIDTH:0]     sum, r2, diff;
   logic [2*WIDTH-1:0] prod;
   logic               neg;

   // Next-state, datapath step and sign-fixup logic
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      sa_d     = sa_q;
      sb_d     = sb_q;
      bmag_d   = bmag_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      dz_d     = dz_q;

      amag = (!op[0] && a[WIDTH-1]) ? -a : a;
      bmag = (!op[0] && b[WIDTH-1]) ? -b : b;
      sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, bmag_q} : '0);
      r2   = {acc_hi_q, acc_lo_q[WIDTH-1]};
      diff = r2 - {1'b0, bmag_q};
      prod = {acc_hi_q, acc_lo_q};
      neg  = !op_q[0] && (sa_q ^ sb_q);

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               op_d     = op;
               sa_d     = a[WIDTH-1];
               sb_d     = b[WIDTH-1];
               bmag_d   = bmag;
               acc_hi_d = '0;
               acc_lo_d = amag;
               cnt_d    = '0;
               state_d  = S_RUN;
               if (op[1] && b == '0) begin
                  hi_d    = a;
                  lo_d    = '0;
                  dz_d    = 1'b1;
                  state_d = S_DONE;
               end
`ifdef MULDIV_ZERO_SKIP_EN
               else if ((!op[1] && (a == '0 || b == '0)) ||
                        (op[1] && a == '0)) begin
                  hi_d    = '0;
                  lo_d    = '0;
                  dz_d    = 1'b0;
                  state_d = S_DONE;
               end
`endif
            end
         end
         S_RUN: begin
            if (!op_q[1]) begin
               acc_hi_d = sum[WIDTH:1];
               acc_lo_d = {sum[0], acc_lo_q[WIDTH-1:1]};
            end else if (!diff[WIDTH]) begin
               acc_hi_d = diff[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_hi_d = r2[WIDTH-1:0];
               acc_lo_d = {acc_lo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(WIDTH - 1))
               state_d = S_FIX;
            if (abort)
               state_d = S_IDLE;
         end
         S_FIX: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               if (!op_q[1]) begin
                  {hi_d, lo_d} = neg ? -prod : prod;
               end else begin
                  lo_d = neg ? -acc_lo_q : acc_lo_q;
                  hi_d = (!op_q[0] && sa_q) ? -acc_hi_q : acc_hi_q;
               end
               dz_d    = 1'b0;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      ready_d = (state_d == S_DONE);
      busy_d  = (state_d != S_IDLE);
   end

   // State and registered outputs, synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         op_q     <= '0;
         sa_q     <= 1'b0;
         sb_q     <= 1'b0;
         bmag_q   <= '0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
         dz_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         sa_q     <= sa_d;
         sb_q     <= sb_d;
         bmag_q   <= bmag_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
         dz_q     <= dz_d;
      end
   end

   assign hi       = hi_q;
   assign lo       = lo_q;
   assign ready    = ready_q;
   assign busy     = busy_q;
   assign div_zero = dz_q;

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter: WIDTH, default 32, operand/result width (>= 4, even).
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-low reset.
REQ-004 SHALL have port: start  input  1  request to begin an operation.
REQ-005 SHALL have port: abort  input  1  cancel the in-flight operation (exception path).
REQ-006 SHALL have port: op  input  2  00 MULT signed, 01 MULTU, 10 DIV signed, 11 DIVU.
REQ-007 SHALL have port: a  input  WIDTH  multiplicand or dividend.
REQ-008 SHALL have port: b  input  WIDTH  multiplier or divisor.
REQ-009 SHALL have port: hi  output  WIDTH  product upper half or remainder.
REQ-010 SHALL have port: lo  output  WIDTH  product lower half or quotient.
REQ-011 SHALL have port: ready  output  1  one-cycle pulse; hi/lo/div_zero valid.
REQ-012 SHALL have port: busy  output  1  high in every non-IDLE state.
REQ-013 SHALL have port: div_zero  output  1  last DIV/DIVU had b == 0.

Function
REQ-014 SHALL implement the FSM states IDLE, RUN, FIX and DONE.
REQ-015 SHALL, in IDLE with start=1, latch op/a/b, load operand magnitudes for signed ops, clear the bit counter, and enter RUN.
REQ-016 SHALL process one bit per cycle in RUN (shift-add multiply; restoring divide on magnitudes), then enter FIX after exactly WIDTH cycles.
REQ-017 SHALL use FIX to apply sign correction: product negated if sign(a) != sign(b); quotient negated if sign(a) != sign(b); remainder takes sign of a. Unsigned ops pass through. FIX then enters DONE.
REQ-018 SHALL update hi/lo on the edge entering DONE, assert ready=1 for exactly that one cycle, then return to IDLE.
REQ-019 SHALL, for a normal operation, assert ready in the cycle following the (WIDTH+2)th edge after the edge that sampled start.
REQ-020 SHALL hold hi/lo/div_zero stable from DONE until the next DONE or reset.
REQ-021 SHALL ignore start while busy=1, with no effect on the current operation.
REQ-022 SHALL permit start=1 in the DONE cycle, but SHALL NOT accept it; a new operation is accepted only from IDLE.
REQ-023 SHALL, for DIV/DIVU with b == 0 at start, go IDLE->DONE on the next edge with hi=a, lo=0 and div_zero=1; div_zero SHALL be cleared by any other completed operation.
REQ-024 SHALL, for signed DIV of the most negative value by -1, produce lo=most negative value and hi=0, with no flag.
REQ-025 SHALL make multiply results full 2*WIDTH bits with {hi,lo} = product, and SHALL never truncate.
REQ-026 SHALL, when abort=1 in RUN or FIX, return to IDLE on that edge with no ready pulse and hi/lo/div_zero unchanged.
REQ-027 SHALL give abort priority over completion, and SHALL ignore abort in IDLE and DONE.
REQ-028 SHALL give simultaneous abort and start in IDLE no abort effect, so start is accepted.

Reset
REQ-029 SHALL, on reset=0 sampled at a clock edge, go to IDLE and set hi=0, lo=0, ready=0, busy=0, div_zero=0, and clear the internal counter/accumulators.
REQ-030 SHALL override start, abort and any in-flight operation with reset; no ready pulse SHALL follow a mid-operation reset.

Configuration
REQ-031 SHALL honour macro MULDIV_ZERO_SKIP_EN: when defined, a MULT/MULTU with a == 0 or b == 0, or a DIV/DIVU with a == 0 and b != 0, SHALL skip RUN/FIX, go IDLE->DONE next edge with hi=0, lo=0, and ready one edge after start sampling.
REQ-032 SHALL, when MULDIV_ZERO_SKIP_EN is undefined, give zero operands (other than the divide-by-zero case) the full WIDTH+2 latency with identical results.

Verification (WIDTH=32)
REQ-033 SHALL cover: MULT a=FFFFFFFD (-3), b=00000007 -> hi=FFFFFFFF, lo=FFFFFFEB; ready exactly 34 edges after start; busy high throughout.
REQ-034 SHALL cover: MULTU a=b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001; div_zero=0.
REQ-035 SHALL cover: DIV a=FFFFFFF9 (-7), b=00000002 -> lo=FFFFFFFD, hi=FFFFFFFF; then DIVU a=00000064, b=00000000 -> ready after 1 edge, hi=00000064, lo=0, div_zero=1.
REQ-036 SHALL cover: MULTU 5*6 completed, then start DIVU, abort at RUN cycle 10 -> no ready, busy low next cycle, hi=0, lo=0000001E retained; start pulses during RUN ignored.
REQ-037 SHALL cover: reset=0 at RUN cycle 20 -> next cycle all outputs 0, state IDLE; subsequent start completes normally.
REQ-038 SHALL cover: with MULDIV_ZERO_SKIP_EN, MULT a=0, b=12345678 -> ready 1 edge after start, hi=lo=0; without the macro -> 34 edges, same result.
